uart_rx: RTL

//  Serial receiver paired with the uartTx/uartBaudGen transmit path. Takes an async
//  8N1 line and a 16x oversample strobe from a second uartBaudGen instance (baudDiv/16).

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sampler.sv | 50 +++++
 rtl/uart_rx.sv | 119 +++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state codes, defaults and the
// 3-sample majority helper used by the bit sampler.
package uart_rx_pkg;

  localparam int unsigned UARTRX_OVERSAMPLE  = 16;
  localparam int unsigned UARTRX_SYNC_STAGES = 2;
  localparam int unsigned UARTRX_DATA_W      = 8;

  typedef enum logic [2:0] {
    UARTRX_IDLE     = 3'd0,
    UARTRX_START    = 3'd1,
    UARTRX_DATA     = 3'd2,
    UARTRX_STOP     = 3'd3,
    UARTRX_WAITHIGH = 3'd4
  } uartRxState_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver (master) and its register-side consumer.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [UARTRX_DATA_W-1:0] rxData;
  logic                     rxReady;
  logic                     rxFrameErr;
  logic                     rxOverrun;
  logic                     rxBreak;
  logic                     rxRead;

  modport master (
    output rxData, rxReady, rxFrameErr, rxOverrun, rxBreak,
    input  rxRead
  );

  modport slave (
    input  rxData, rxReady, rxFrameErr, rxOverrun, rxBreak,
    output rxRead
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus majority vote over the three samples around mid-bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter  int unsigned OVERSAMPLE  = UARTRX_OVERSAMPLE,
  parameter  int unsigned SYNC_STAGES = UARTRX_SYNC_STAGES,
  localparam int unsigned CNT_W       = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sampleEn,
  input  logic             rxIn,
  input  logic [CNT_W-1:0] sampleCnt,
  output logic             rxSync,
  output logic             vote_c
);

  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(MID);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   sampleEarly;
  logic                   sampleMid;

  // Idle-high synchronizer; the only consumer of the raw line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      syncQ <= '1;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], rxIn};
    end
  end

  assign rxSync = syncQ[SYNC_STAGES-1];

  // The third vote sample is the live rxSync at mid+1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sampleEarly <= 1'b1;
      sampleMid   <= 1'b1;
    end else if (sampleEn) begin
      if (sampleCnt == CNT_EARLY) sampleEarly <= rxSync;
      if (sampleCnt == CNT_MID)   sampleMid   <= rxSync;
    end
  end

  assign vote_c = majority3(sampleEarly, sampleMid, rxSync);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled bit FSM, shift register and ready/read
// byte handshake with framing, overrun and break status.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = UARTRX_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = UARTRX_SYNC_STAGES
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sampleEn,
  input  logic      rxIn,
  uart_rx_if.master rxBus
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  uartRxState_t             state;
  logic [CNT_W-1:0]         sampleCnt;
  logic [2:0]               bitIdx;
  logic [UARTRX_DATA_W-1:0] shiftReg;
  logic                     rxSync;
  logic                     vote_c;
  logic                     voteTick_c;
  logic                     byteDone_c;

  uart_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .sampleEn  (sampleEn),
    .rxIn      (rxIn),
    .sampleCnt (sampleCnt),
    .rxSync    (rxSync),
    .vote_c    (vote_c)
  );

  assign voteTick_c = sampleEn && (sampleCnt == CNT_VOTE);
  // Byte completes half a stop bit early so the next start edge is never missed.
  assign byteDone_c = voteTick_c && (state == UARTRX_STOP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= UARTRX_IDLE;
      sampleCnt         <= '0;
      bitIdx            <= '0;
      shiftReg          <= '0;
      rxBus.rxData      <= '0;
      rxBus.rxReady     <= 1'b0;
      rxBus.rxFrameErr  <= 1'b0;
      rxBus.rxOverrun   <= 1'b0;
      rxBus.rxBreak     <= 1'b0;
    end else begin
      rxBus.rxBreak <= 1'b0;

      if (sampleEn) begin
        case (state)
          UARTRX_IDLE: begin
            if (!rxSync) begin
              state     <= UARTRX_START;
              sampleCnt <= '0;
            end
          end
          UARTRX_START: begin
            sampleCnt <= sampleCnt + 1'b1;
            if (sampleCnt == CNT_VOTE && vote_c) begin
              state <= UARTRX_IDLE;
            end else if (sampleCnt == CNT_LAST) begin
              state  <= UARTRX_DATA;
              bitIdx <= '0;
            end
          end
          UARTRX_DATA: begin
            sampleCnt <= sampleCnt + 1'b1;
            if (sampleCnt == CNT_VOTE) begin
              shiftReg <= {vote_c, shiftReg[UARTRX_DATA_W-1:1]};
            end
            if (sampleCnt == CNT_LAST) begin
              if (bitIdx == 3'd7) state <= UARTRX_STOP;
              else                bitIdx <= bitIdx + 3'd1;
            end
          end
          UARTRX_STOP: begin
            sampleCnt <= sampleCnt + 1'b1;
            if (sampleCnt == CNT_VOTE) begin
              state <= vote_c ? UARTRX_IDLE : UARTRX_WAITHIGH;
            end
          end
          UARTRX_WAITHIGH: begin
            if (rxSync) state <= UARTRX_IDLE;
          end
          default: state <= UARTRX_IDLE;
        endcase
      end

      // Handshake runs every clk, independent of sampleEn.
      if (byteDone_c) begin
        if (!rxBus.rxReady || rxBus.rxRead) begin
          rxBus.rxData     <= shiftReg;
          rxBus.rxFrameErr <= ~vote_c;
          rxBus.rxReady    <= 1'b1;
          if (rxBus.rxRead) rxBus.rxOverrun <= 1'b0;
        end else begin
          rxBus.rxOverrun <= 1'b1;
        end
        rxBus.rxBreak <= (shiftReg == '0) && !vote_c;
      end else if (rxBus.rxRead) begin
        rxBus.rxReady   <= 1'b0;
        rxBus.rxOverrun <= 1'b0;
      end
    end
  end

endmodule
